// File: rtl/ui_msg_scheduler.sv
// Frame-synchronous UI message scheduler: picks which overlay string to show and when.
// Define UI_MSG_PENDING_EN to queue pulse requests in every state (default: only in idle).
module ui_msg_scheduler #(
    parameter int unsigned NUM_SRC     = 2,
    parameter logic [15:0] HOLD_FRAMES = 16'd120
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               vsync,
    input  logic [NUM_SRC-1:0] level_req,
    input  logic [NUM_SRC-1:0] pulse_req,
    output logic               ui_enable,
    output logic [2:0]         string_index,
    output logic               busy
);

    localparam logic [15:0] HOLD_LOAD = (HOLD_FRAMES == 16'd0) ? 16'd1 : HOLD_FRAMES;

    typedef enum logic [1:0] {StIdle, StArm, StShow} state_e;

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [2:0]         cur_q, cur_d;
    logic               kind_lvl_q, kind_lvl_d;
    logic               ui_enable_q;
    logic [2:0]         string_index_q;
    logic               busy_q;

    logic [NUM_SRC-1:0] req;
    logic               req_any, req_lvl, lvl_any, cur_lvl;
    logic [2:0]         req_idx, lvl_idx;

    logic               enter, enter_lvl, repend, capture, done;
    logic [2:0]         enter_idx;

    // Lowest-index arbitration over all requests and over level requests only.
    always_comb begin
        req     = level_req | pend_q;
        req_any = 1'b0;
        req_idx = '0;
        req_lvl = 1'b0;
        lvl_any = 1'b0;
        lvl_idx = '0;
        cur_lvl = 1'b0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (req[i] && !req_any) begin
                req_any = 1'b1;
                req_idx = 3'(i);
                req_lvl = level_req[i];
            end
            if (level_req[i] && !lvl_any) begin
                lvl_any = 1'b1;
                lvl_idx = 3'(i);
            end
            if (3'(i) == cur_q) begin
                cur_lvl = level_req[i];
            end
        end
    end

`ifdef UI_MSG_PENDING_EN
    assign capture = 1'b1;
`else
    assign capture = (state_q == StIdle);
`endif

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        kind_lvl_d = kind_lvl_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        enter      = 1'b0;
        enter_idx  = req_idx;
        enter_lvl  = req_lvl;
        repend     = 1'b0;
        done       = kind_lvl_q ? !cur_lvl : (cnt_q <= 16'd1);

        unique case (state_q)
            StIdle: begin
                if (req_any) begin
                    state_d    = StArm;
                    cur_d      = req_idx;
                    kind_lvl_d = req_lvl;
                end
            end
            StArm: begin
                // Re-arbitrate at the frame edge; the request may have changed since arming.
                if (vsync) begin
                    if (req_any) enter = 1'b1;
                    else         state_d = StIdle;
                end
            end
            StShow: begin
                if (vsync) begin
                    if (done) begin
                        if (req_any) enter = 1'b1;
                        else         state_d = StIdle;
                    end else if (lvl_any && (lvl_idx < cur_q)) begin
                        enter     = 1'b1;
                        enter_idx = lvl_idx;
                        enter_lvl = 1'b1;
                        repend    = !kind_lvl_q;
                    end else if (!kind_lvl_q) begin
                        cnt_d = cnt_q - 16'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (enter) begin
            state_d    = StShow;
            cur_d      = enter_idx;
            kind_lvl_d = enter_lvl;
            cnt_d      = HOLD_LOAD;
        end

        // Clear on entry, re-queue a preempted pulse, then new pulses win over the clear.
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (enter && (3'(i) == enter_idx)) pend_d[i] = 1'b0;
            if (repend && (3'(i) == cur_q))    pend_d[i] = 1'b1;
            if (capture && pulse_req[i])       pend_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= StIdle;
            pend_q         <= '0;
            cnt_q          <= '0;
            cur_q          <= '0;
            kind_lvl_q     <= 1'b0;
            ui_enable_q    <= 1'b0;
            string_index_q <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
            cur_q       <= cur_d;
            kind_lvl_q  <= kind_lvl_d;
            ui_enable_q <= (state_d == StShow);
            busy_q      <= (state_d != StIdle);
            if (enter) begin
                string_index_q <= enter_idx;
            end
        end
    end

    assign ui_enable    = ui_enable_q;
    assign string_index = string_index_q;
    assign busy         = busy_q;

endmodule
